hazard_redirect_unit: RTL and testbench

Drives the control inputs of pc_control: stall, branch, jumpReg, branchAddress and jumpAddress. It also drives the pipeline flush strobes. It detects load-use hazards and multi-cycle data-memory waits, and resolves taken branches and jr in EX into PC redirects. It sits between the ID/EX pipeline registers and pc_control, and it keeps saturating performance counters.

---
 rtl/hazard_redirect_unit.sv | 187 ++++++++++++++++++
 tb/tb_hazard_redirect_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_redirect_unit.sv
// Hazard detection and PC redirect control for pc_control: load-use and data-memory stalls,
// taken-branch / jr redirects resolved in EX, pipeline flush strobes and saturating perf counters.
module hazard_redirect_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             ex_jump_reg,
    input  logic [31:0]      ex_jump_target,
    input  logic             dmem_busy,
    output logic             stall,
    output logic             branch,
    output logic             jumpReg,
    output logic [31:0]      branchAddress,
    output logic [31:0]      jumpAddress,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_events,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD_STALL,
        ST_MEM_WAIT,
        ST_FLUSH
    } state_t;

    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       ld_cnt_q, ld_cnt_d;
    logic [31:0]      br_addr_q, br_addr_d;
    logic [31:0]      jr_addr_q, jr_addr_d;
    logic [CNT_W-1:0] stall_events_q, stall_events_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

    logic load_use;
    logic jr_req;
    logic br_req;
    logic run_rules;
    logic stall_c;
    logic branch_c;
    logic jump_reg_c;
    logic flush_if_id_c;
    logic flush_id_ex_c;
    logic stall_evt_c;

    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                   ((id_rs == ex_rt) || (id_uses_rt && (id_rt == ex_rt)));
        jr_req   = ex_valid && ex_jump_reg;
        br_req   = ex_valid && ex_branch && ex_branch_taken;
    end

    // MEM_WAIT falls through to the RUN rules on its first non-busy cycle, so the
    // RUN decision is shared via run_rules instead of being duplicated per state.
    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        run_rules     = 1'b0;
        stall_c       = 1'b0;
        branch_c      = 1'b0;
        jump_reg_c    = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        stall_evt_c   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                run_rules = 1'b1;
            end
            ST_LOAD_STALL: begin
                stall_c       = 1'b1;
                flush_id_ex_c = 1'b1;
                if (!dmem_busy) begin
                    ld_cnt_d = ld_cnt_q - 3'd1;
                    if (ld_cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_busy) begin
                    stall_c = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (dmem_busy) begin
                    stall_c     = 1'b1;
                    stall_evt_c = 1'b1;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_rules) begin
            state_d = ST_RUN;
            if (dmem_busy) begin
                stall_c     = 1'b1;
                stall_evt_c = 1'b1;
                state_d     = ST_MEM_WAIT;
            end else if (jr_req) begin
                jump_reg_c    = 1'b1;
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
                state_d       = ST_FLUSH;
            end else if (br_req) begin
                branch_c      = 1'b1;
                flush_if_id_c = 1'b1;
                flush_id_ex_c = 1'b1;
                state_d       = ST_FLUSH;
            end else if (load_use) begin
                stall_c       = 1'b1;
                flush_id_ex_c = 1'b1;
                stall_evt_c   = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    ld_cnt_d = LOAD_RELOAD;
                    state_d  = ST_LOAD_STALL;
                end
            end
        end
    end

    always_comb begin
        br_addr_d        = branch_c ? ex_branch_target : br_addr_q;
        jr_addr_d        = jump_reg_c ? ex_jump_target : jr_addr_q;
        stall_events_d   = stall_events_q;
        redirect_count_d = redirect_count_q;
        if (stall_evt_c && (stall_events_q != '1)) begin
            stall_events_d = stall_events_q + CNT_W'(1);
        end
        if ((branch_c || jump_reg_c) && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            ld_cnt_q         <= '0;
            br_addr_q        <= '0;
            jr_addr_q        <= '0;
            stall_events_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            ld_cnt_q         <= ld_cnt_d;
            br_addr_q        <= br_addr_d;
            jr_addr_q        <= jr_addr_d;
            stall_events_q   <= stall_events_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    // Every output is forced low while reset is held, including mid-episode.
    always_comb begin
        stall          = reset ? 1'b0 : stall_c;
        branch         = reset ? 1'b0 : branch_c;
        jumpReg        = reset ? 1'b0 : jump_reg_c;
        flush_if_id    = reset ? 1'b0 : flush_if_id_c;
        flush_id_ex    = reset ? 1'b0 : flush_id_ex_c;
        branchAddress  = reset ? '0 : (branch_c ? ex_branch_target : br_addr_q);
        jumpAddress    = reset ? '0 : (jump_reg_c ? ex_jump_target : jr_addr_q);
        stall_events   = reset ? '0 : stall_events_q;
        redirect_count = reset ? '0 : redirect_count_q;
    end

endmodule

// File: tb/tb_hazard_redirect_unit.sv
// Scoreboard bench: two configurations driven with shared directed + random stimulus,
// expected outputs from a behavioural model pushed per cycle and checked by a monitor.
module tb_hazard_redirect_unit;

    typedef struct packed {
        logic        reset;
        logic        id_valid;
        logic [4:0]  id_rs;
        logic [4:0]  id_rt;
        logic        id_uses_rt;
        logic        ex_valid;
        logic        ex_mem_read;
        logic [4:0]  ex_rt;
        logic        ex_branch;
        logic        ex_branch_taken;
        logic [31:0] ex_branch_target;
        logic        ex_jump_reg;
        logic [31:0] ex_jump_target;
        logic        dmem_busy;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        branch;
        logic        jr;
        logic        fif;
        logic        fie;
        logic [31:0] ba;
        logic [31:0] ja;
        logic [31:0] sev;
        logic [31:0] rc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        id_valid = 1'b0, id_uses_rt = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_branch = 1'b0, ex_branch_taken = 1'b0;
    logic        ex_jump_reg = 1'b0, dmem_busy = 1'b0;
    logic [31:0] ex_branch_target = '0, ex_jump_target = '0;

    logic        a_stall, a_branch, a_jr, a_fif, a_fie;
    logic [31:0] a_ba, a_ja;
    logic [15:0] a_sev, a_rc;
    logic        b_stall, b_branch, b_jr, b_fif, b_fie;
    logic [31:0] b_ba, b_ja;
    logic [4:0]  b_sev, b_rc;

    hazard_redirect_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_jump_reg(ex_jump_reg), .ex_jump_target(ex_jump_target), .dmem_busy(dmem_busy),
        .stall(a_stall), .branch(a_branch), .jumpReg(a_jr), .branchAddress(a_ba), .jumpAddress(a_ja),
        .flush_if_id(a_fif), .flush_id_ex(a_fie), .stall_events(a_sev), .redirect_count(a_rc)
    );

    hazard_redirect_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_jump_reg(ex_jump_reg), .ex_jump_target(ex_jump_target), .dmem_busy(dmem_busy),
        .stall(b_stall), .branch(b_branch), .jumpReg(b_jr), .branchAddress(b_ba), .jumpAddress(b_ja),
        .flush_if_id(b_fif), .flush_id_ex(b_fie), .stall_events(b_sev), .redirect_count(b_rc)
    );

    int n_cmp = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Reference model state, one slot per configuration.
    int          m_load[2]  = '{0, 0};
    bit          m_wait[2]  = '{0, 0};
    bit          m_flush[2] = '{0, 0};
    logic [31:0] m_ba[2]    = '{0, 0};
    logic [31:0] m_ja[2]    = '{0, 0};
    int          m_sev[2]   = '{0, 0};
    int          m_rc[2]    = '{0, 0};

    function automatic int sat_inc(input int v, input int w);
        int top = (1 << w) - 1;
        return (v < top) ? v + 1 : top;
    endfunction

    task automatic model_step(input int k, input int ld, input int w, input stim_t s, output exp_t e);
        bit lu;
        e = '0;
        if (s.reset) begin
            m_load[k] = 0; m_wait[k] = 0; m_flush[k] = 0;
            m_ba[k] = '0; m_ja[k] = '0; m_sev[k] = 0; m_rc[k] = 0;
            return;
        end
        e.sev = m_sev[k];
        e.rc  = m_rc[k];
        e.ba  = m_ba[k];
        e.ja  = m_ja[k];
        lu = s.ex_valid && s.ex_mem_read && (s.ex_rt != 0) && s.id_valid &&
             ((s.id_rs == s.ex_rt) || (s.id_uses_rt && (s.id_rt == s.ex_rt)));
        if (m_load[k] > 0) begin
            e.stall = 1; e.fie = 1;
            if (!s.dmem_busy) m_load[k]--;
        end else if (m_flush[k]) begin
            m_flush[k] = 0;
            if (s.dmem_busy) begin
                e.stall = 1; m_wait[k] = 1; m_sev[k] = sat_inc(m_sev[k], w);
            end
        end else if (s.dmem_busy) begin
            e.stall = 1;
            if (!m_wait[k]) begin
                m_wait[k] = 1; m_sev[k] = sat_inc(m_sev[k], w);
            end
        end else begin
            m_wait[k] = 0;
            if (s.ex_valid && s.ex_jump_reg) begin
                e.jr = 1; e.fif = 1; e.fie = 1; e.ja = s.ex_jump_target;
                m_ja[k] = s.ex_jump_target; m_rc[k] = sat_inc(m_rc[k], w); m_flush[k] = 1;
            end else if (s.ex_valid && s.ex_branch && s.ex_branch_taken) begin
                e.branch = 1; e.fif = 1; e.fie = 1; e.ba = s.ex_branch_target;
                m_ba[k] = s.ex_branch_target; m_rc[k] = sat_inc(m_rc[k], w); m_flush[k] = 1;
            end else if (lu) begin
                e.stall = 1; e.fie = 1;
                m_sev[k] = sat_inc(m_sev[k], w);
                m_load[k] = ld - 1;
            end
        end
    endtask

    task automatic step(input stim_t s);
        exp_t ea, eb;
        @(posedge clk);
        #1;
        reset = s.reset; id_valid = s.id_valid; id_rs = s.id_rs; id_rt = s.id_rt;
        id_uses_rt = s.id_uses_rt; ex_valid = s.ex_valid; ex_mem_read = s.ex_mem_read;
        ex_rt = s.ex_rt; ex_branch = s.ex_branch; ex_branch_taken = s.ex_branch_taken;
        ex_branch_target = s.ex_branch_target; ex_jump_reg = s.ex_jump_reg;
        ex_jump_target = s.ex_jump_target; dmem_busy = s.dmem_busy;
        model_step(0, 1, 16, s, ea);
        model_step(1, 3, 5, s, eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a.stall", 32'(a_stall), 32'(e.stall));
            chk("a.branch", 32'(a_branch), 32'(e.branch));
            chk("a.jumpReg", 32'(a_jr), 32'(e.jr));
            chk("a.flush_if_id", 32'(a_fif), 32'(e.fif));
            chk("a.flush_id_ex", 32'(a_fie), 32'(e.fie));
            chk("a.branchAddress", a_ba, e.ba);
            chk("a.jumpAddress", a_ja, e.ja);
            chk("a.stall_events", 32'(a_sev), e.sev);
            chk("a.redirect_count", 32'(a_rc), e.rc);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b.stall", 32'(b_stall), 32'(e.stall));
            chk("b.branch", 32'(b_branch), 32'(e.branch));
            chk("b.jumpReg", 32'(b_jr), 32'(e.jr));
            chk("b.flush_if_id", 32'(b_fif), 32'(e.fif));
            chk("b.flush_id_ex", 32'(b_fie), 32'(e.fie));
            chk("b.branchAddress", b_ba, e.ba);
            chk("b.jumpAddress", b_ja, e.ja);
            chk("b.stall_events", 32'(b_sev), e.sev);
            chk("b.redirect_count", 32'(b_rc), e.rc);
        end
    end

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = '0;
        s.reset            = ($urandom_range(99) < 2);
        s.id_valid         = ($urandom_range(99) < 85);
        s.id_rs            = 5'($urandom_range(3));
        s.id_rt            = 5'($urandom_range(3));
        s.id_uses_rt       = ($urandom_range(1) == 1);
        s.ex_valid         = ($urandom_range(99) < 85);
        s.ex_mem_read      = ($urandom_range(99) < 35);
        s.ex_rt            = 5'($urandom_range(3));
        s.ex_branch        = ($urandom_range(99) < 30);
        s.ex_branch_taken  = ($urandom_range(1) == 1);
        s.ex_branch_target = $urandom;
        s.ex_jump_reg      = ($urandom_range(99) < 10);
        s.ex_jump_target   = $urandom;
        s.dmem_busy        = ($urandom_range(99) < 15);
        return s;
    endfunction

    initial begin
        stim_t s;
        int    guard;

        s = idle(); s.reset = 1;
        repeat (2) step(s);
        repeat (3) step(idle());

        // taken branch, held in EX across the flush cycle
        s = idle(); s.ex_valid = 1; s.ex_branch = 1; s.ex_branch_taken = 1; s.ex_branch_target = 32'd20;
        repeat (2) step(s);
        repeat (2) step(idle());

        // jr and taken branch together
        s.ex_jump_reg = 1; s.ex_jump_target = 32'd40; s.ex_branch_target = 32'd60;
        step(s);
        repeat (2) step(idle());

        // load-use on rs, rt without uses_rt, and r0
        s = idle(); s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rt = 5'd5; s.id_valid = 1; s.id_rs = 5'd5;
        step(s);
        repeat (3) step(idle());
        s.id_rs = 5'd1; s.id_rt = 5'd5; s.id_uses_rt = 0;
        step(s);
        s.ex_rt = 5'd0; s.id_rs = 5'd0; s.id_rt = 5'd0; s.id_uses_rt = 1;
        step(s);
        repeat (2) step(idle());

        // load-use with memory busy in the middle of the stall
        s = idle(); s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rt = 5'd5; s.id_valid = 1; s.id_rs = 5'd5;
        step(s);
        step(idle());
        s = idle(); s.dmem_busy = 1;
        repeat (2) step(s);
        repeat (3) step(idle());

        // taken branch waiting behind a busy data memory
        s = idle(); s.ex_valid = 1; s.ex_branch = 1; s.ex_branch_taken = 1; s.ex_branch_target = 32'd100;
        s.dmem_busy = 1;
        repeat (4) step(s);
        s.dmem_busy = 0;
        step(s);
        repeat (2) step(idle());

        // reset during LOAD_STALL, then during MEM_WAIT
        s = idle(); s.ex_valid = 1; s.ex_mem_read = 1; s.ex_rt = 5'd7; s.id_valid = 1; s.id_rs = 5'd7;
        step(s);
        s = idle(); s.reset = 1;
        step(s);
        repeat (2) step(idle());
        s = idle(); s.dmem_busy = 1;
        repeat (2) step(s);
        s.reset = 1;
        step(s);
        repeat (2) step(idle());

        for (int i = 0; i < 3000; i++) step(rand_stim());

        // redirect saturation on the narrow counter
        s = idle(); s.reset = 1;
        step(s);
        for (int i = 0; i < 40; i++) begin
            s = idle(); s.ex_valid = 1; s.ex_branch = 1; s.ex_branch_taken = 1; s.ex_branch_target = $urandom;
            step(s);
            step(idle());
        end

        guard = 0;
        while ((qa.size() != 0 || qb.size() != 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", qa.size() + qb.size());
        end
        @(negedge clk);
        #1;
        chk("b.redirect_count_saturated", 32'(b_rc), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
